// File: rtl/alu_commit_arbiter_if.sv
// Core sizing constants plus the ALU-bank / commit-stage bundle used by alu_commit_arbiter.
// master = arbiter side, slave = ALU bank plus commit stage.
package core_config_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
endpackage

interface alu_commit_arbiter_if #(
    parameter int N_UNITS    = 6,
    parameter int XLEN       = core_config_pkg::XLEN,
    parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
);
    localparam int UNIT_W = $clog2(N_UNITS);

    logic [N_UNITS-1:0]                 unit_req;
    logic [N_UNITS-1:0]                 unit_valid;
    logic [N_UNITS-1:0][XLEN-1:0]       unit_res;
    logic [N_UNITS-1:0][REG_ADDR_W-1:0] unit_rd;
    logic [N_UNITS-1:0]                 unit_error;
    logic [N_UNITS-1:0]                 unit_clear;
    logic                               flush;
    logic                               wb_valid;
    logic [XLEN-1:0]                    wb_data;
    logic [REG_ADDR_W-1:0]              wb_rd;
    logic                               wb_error;
    logic [UNIT_W-1:0]                  wb_unit;
    logic                               wb_ready;

    modport master (
        input  unit_req, unit_valid, unit_res, unit_rd, unit_error, flush, wb_ready,
        output unit_clear, wb_valid, wb_data, wb_rd, wb_error, wb_unit
    );

    modport slave (
        output unit_req, unit_valid, unit_res, unit_rd, unit_error, flush, wb_ready,
        input  unit_clear, wb_valid, wb_data, wb_rd, wb_error, wb_unit
    );
endinterface

// File: rtl/alu_commit_arbiter.sv
// Round-robin commit arbiter: picks one finished ALU result per load slot, registers it
// for the register-file writeback port and pulses the winner's clear.

module alu_commit_lane #(
    parameter int IDX    = 0,
    parameter int UNIT_W = 3
) (
    input  logic              req,
    input  logic              valid,
    input  logic              grant,
    input  logic [UNIT_W-1:0] win,
    output logic              cand,
    output logic              clear
);
    // req without valid is not a finished result and never competes
    assign cand  = req & valid;
    assign clear = grant && (win == UNIT_W'(IDX));
endmodule

module alu_commit_arbiter #(
    parameter int N_UNITS    = 6,
    parameter int XLEN       = core_config_pkg::XLEN,
    parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
    input logic                  clk,
    input logic                  rst,
    alu_commit_arbiter_if.master bus
);
    localparam int UNIT_W = $clog2(N_UNITS);

    typedef enum logic {EMPTY, FULL} state_t;

    typedef struct packed {
        logic [XLEN-1:0]       data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  error;
        logic [UNIT_W-1:0]     unit;
    } wb_entry_t;

    state_t             state_q, state_d;
    wb_entry_t          wb_q;
    logic [UNIT_W-1:0]  last_q;
    logic [UNIT_W-1:0]  win;
    logic [UNIT_W-1:0]  scan_idx;
    logic [N_UNITS-1:0] cand;
    logic               any_cand;
    logic               load;
    logic               grant;

    for (genvar i = 0; i < N_UNITS; i++) begin : g_lane
        alu_commit_lane #(.IDX(i), .UNIT_W(UNIT_W)) u_lane (
            .req   (bus.unit_req[i]),
            .valid (bus.unit_valid[i]),
            .grant (grant),
            .win   (win),
            .cand  (cand[i]),
            .clear (bus.unit_clear[i])
        );
    end

    // Scan from the farthest slot back toward last_q+1 so the nearest candidate wins.
    always_comb begin
        win      = '0;
        any_cand = 1'b0;
        scan_idx = '0;
        for (int k = N_UNITS; k >= 1; k--) begin
            scan_idx = UNIT_W'((int'(last_q) + k) % N_UNITS);
            if (cand[scan_idx]) begin
                win      = scan_idx;
                any_cand = 1'b1;
            end
        end
    end

    // Flush outranks both the consumer and new candidates; reset kills the clear pulse.
    assign load  = !bus.flush && ((state_q == EMPTY) || bus.wb_ready);
    assign grant = !rst && load && any_cand;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (grant) state_d = FULL;
            FULL: begin
                if (bus.flush)         state_d = EMPTY;
                else if (bus.wb_ready) state_d = grant ? FULL : EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            last_q  <= UNIT_W'(N_UNITS - 1);
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            // Data registers only move on a grant; a drain just drops the valid state.
            if (grant) begin
                wb_q.data  <= bus.unit_res[win];
                wb_q.rd    <= bus.unit_rd[win];
                wb_q.error <= bus.unit_error[win];
                wb_q.unit  <= win;
                last_q     <= win;
            end
        end
    end

    assign bus.wb_valid = (state_q == FULL);
    assign bus.wb_data  = wb_q.data;
    assign bus.wb_rd    = wb_q.rd;
    assign bus.wb_error = wb_q.error;
    assign bus.wb_unit  = wb_q.unit;
endmodule

// File: tb/tb_alu_commit_arbiter.sv
// Bench for alu_commit_arbiter: directed vector table, hand sequences, and random traffic
// checked against a queue-free reference of the round-robin commit rules.
module tb_alu_commit_arbiter;
    localparam int N  = 6;
    localparam int XW = core_config_pkg::XLEN;
    localparam int RW = core_config_pkg::REG_ADDR_W;
    localparam int UW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_commit_arbiter_if #(.N_UNITS(N), .XLEN(XW), .REG_ADDR_W(RW)) bus();
    alu_commit_arbiter #(.N_UNITS(N), .XLEN(XW), .REG_ADDR_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Reference state: the held writeback entry and the last granted unit.
    logic          m_v = 1'b0;
    logic [XW-1:0] m_d = '0;
    logic [RW-1:0] m_rd = '0;
    logic          m_e = 1'b0;
    int            m_u = 0;
    int            m_last = N - 1;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] valid;
        logic         fl;
        logic         rdy;
        logic         rs;
        logic [N-1:0] exp_clr;
        logic         exp_v;
        int           exp_u;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First unit with req&valid at distance 1..N after the last grant.
    function automatic int pick(input logic [N-1:0] req, input logic [N-1:0] valid);
        logic [N-1:0] c;
        int j;
        c = req & valid;
        for (int k = 1; k <= N; k++) begin
            j = (m_last + k) % N;
            if (c[UW'(j)]) return j;
        end
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] req, input logic [N-1:0] valid,
                        input logic fl, input logic rdy, input logic rs,
                        output logic [N-1:0] clr);
        int g;
        logic [N-1:0] exp_clr;
        bus.unit_req   = req;
        bus.unit_valid = valid;
        bus.flush      = fl;
        bus.wb_ready   = rdy;
        rst            = rs;
        #1;
        g = pick(req, valid);
        exp_clr = '0;
        if (!rs && !fl && (!m_v || rdy) && g >= 0) exp_clr[UW'(g)] = 1'b1;
        clr = bus.unit_clear;
        chk("unit_clear", 64'(clr), 64'(exp_clr));
        @(posedge clk);
        if (rs) begin
            m_v = 1'b0; m_d = '0; m_rd = '0; m_e = 1'b0; m_u = 0; m_last = N - 1;
        end else if (fl) begin
            m_v = 1'b0;
        end else if (!m_v || rdy) begin
            if (g >= 0) begin
                m_v    = 1'b1;
                m_d    = bus.unit_res[UW'(g)];
                m_rd   = bus.unit_rd[UW'(g)];
                m_e    = bus.unit_error[UW'(g)];
                m_u    = g;
                m_last = g;
            end else begin
                m_v = 1'b0;
            end
        end
        #1;
        chk("wb_valid", 64'(bus.wb_valid), 64'(m_v));
        chk("wb_data",  64'(bus.wb_data),  64'(m_d));
        chk("wb_rd",    64'(bus.wb_rd),    64'(m_rd));
        chk("wb_error", 64'(bus.wb_error), 64'(m_e));
        chk("wb_unit",  64'(bus.wb_unit),  64'(m_u));
    endtask

    task automatic vec(input logic [N-1:0] req, input logic [N-1:0] valid,
                       input logic fl, input logic rdy, input logic rs,
                       input logic [N-1:0] exp_clr, input logic exp_v, input int exp_u);
        vec_t v;
        v.req = req; v.valid = valid; v.fl = fl; v.rdy = rdy; v.rs = rs;
        v.exp_clr = exp_clr; v.exp_v = exp_v; v.exp_u = exp_u;
        tv.push_back(v);
    endtask

    initial begin
        logic [N-1:0] clr;
        logic [N-1:0] r_req, r_val;

        // Directed table: reset, round robin, stall, valid filter, flush, reset mid-flight.
        vec(6'h00, 6'h00, 0, 1, 1, 6'h00, 0, 0);
        vec(6'h3F, 6'h3F, 0, 1, 0, 6'h01, 1, 0);
        vec(6'h3F, 6'h3F, 0, 1, 0, 6'h02, 1, 1);
        vec(6'h3F, 6'h3F, 0, 1, 0, 6'h04, 1, 2);
        vec(6'h3F, 6'h3F, 0, 1, 0, 6'h08, 1, 3);
        vec(6'h3F, 6'h3F, 0, 1, 0, 6'h10, 1, 4);
        vec(6'h3F, 6'h3F, 0, 1, 0, 6'h20, 1, 5);
        vec(6'h3F, 6'h3F, 0, 1, 0, 6'h01, 1, 0);
        vec(6'h12, 6'h3F, 0, 0, 0, 6'h00, 1, 0);
        vec(6'h12, 6'h3F, 0, 0, 0, 6'h00, 1, 0);
        vec(6'h12, 6'h3F, 0, 0, 0, 6'h00, 1, 0);
        vec(6'h12, 6'h3F, 0, 1, 0, 6'h02, 1, 1);
        vec(6'h12, 6'h3F, 0, 1, 0, 6'h10, 1, 4);
        vec(6'h00, 6'h3F, 0, 1, 0, 6'h00, 0, 4);
        vec(6'h28, 6'h20, 0, 1, 0, 6'h20, 1, 5);
        vec(6'h28, 6'h20, 0, 1, 0, 6'h20, 1, 5);
        vec(6'h01, 6'h3F, 1, 0, 0, 6'h00, 0, 5);
        vec(6'h01, 6'h3F, 0, 1, 0, 6'h01, 1, 0);
        vec(6'h03, 6'h3F, 0, 0, 1, 6'h00, 0, 0);
        vec(6'h03, 6'h3F, 0, 1, 0, 6'h01, 1, 0);
        vec(6'h00, 6'h3F, 0, 1, 0, 6'h00, 0, 0);

        for (int i = 0; i < N; i++) begin
            bus.unit_res[i]   = XW'(32'hA500_0000 + 32'(i) * 32'h111);
            bus.unit_rd[i]    = RW'(i + 1);
            bus.unit_error[i] = (i % 2 == 1);
        end

        step('0, '0, 1'b0, 1'b1, 1'b1, clr);

        // Single request from unit 2: same-cycle clear, registered result next cycle.
        bus.unit_res[2]   = 32'hDEAD_BEEF;
        bus.unit_rd[2]    = RW'(5);
        bus.unit_error[2] = 1'b0;
        step(6'b000100, 6'b000100, 1'b0, 1'b1, 1'b0, clr);
        chk("t1_clear", 64'(clr), 64'(6'b000100));
        chk("t1_valid", 64'(bus.wb_valid), 64'(1));
        chk("t1_data",  64'(bus.wb_data), 64'(32'hDEAD_BEEF));
        chk("t1_rd",    64'(bus.wb_rd), 64'(5));
        chk("t1_unit",  64'(bus.wb_unit), 64'(2));

        foreach (tv[i]) begin
            step(tv[i].req, tv[i].valid, tv[i].fl, tv[i].rdy, tv[i].rs, clr);
            chk($sformatf("vec%0d_clear", i), 64'(clr), 64'(tv[i].exp_clr));
            chk($sformatf("vec%0d_valid", i), 64'(bus.wb_valid), 64'(tv[i].exp_v));
            chk($sformatf("vec%0d_unit", i),  64'(bus.wb_unit), 64'(tv[i].exp_u));
        end

        // Hand sequence: rd=0 and error results pass straight through.
        bus.unit_rd[3]    = '0;
        bus.unit_error[3] = 1'b1;
        step(6'b001000, 6'b001000, 1'b0, 1'b1, 1'b0, clr);
        chk("pass_rd0",   64'(bus.wb_rd), 64'(0));
        chk("pass_error", 64'(bus.wb_error), 64'(1));

        // Random traffic against the reference.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                bus.unit_res[i]   = XW'($urandom);
                bus.unit_rd[i]    = RW'($urandom);
                bus.unit_error[i] = ($urandom_range(0, 7) == 0);
            end
            r_req = N'($urandom);
            r_val = N'($urandom) | N'($urandom);
            step(r_req, r_val,
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0), clr);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
